// File: rtl/rf_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_arbiter                                                 |
// | Description : Two-master round-robin arbiter in front of a single-port   |
// |               64-bit register file with registered read. Supports a      |
// |               bounded lock giving one master back-to-back grants, routes |
// |               read data back to the granted master and flags accesses    |
// |               to addresses >= NUM_REGS.                                  |
// | Ports       : clk, reset_n (async, active low)                           |
// |               mX_req/we/addr/wdata/lock  master request side (X = 0, 1)  |
// |               mX_gnt                     combinational grant             |
// |               mX_rvalid/mX_err           return qualifiers               |
// |               rdata                      shared read-data return         |
// |               rf_addr/rf_wdata/rf_we     register-file drive             |
// |               rf_rdata                   register-file read data         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rf_arbiter #(
  parameter int NUM_REGS = 23,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [63:0] rdata,
  output logic [15:0] rf_addr,
  output logic [63:0] rf_wdata,
  output logic        rf_we,
  input  logic [63:0] rf_rdata
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_OWN0    = 2'd1;
  localparam logic [1:0]  ST_OWN1    = 2'd2;
  localparam logic [15:0] ADDR_LIMIT = 16'(NUM_REGS);
  localparam logic [7:0]  LOCK_LIMIT = 8'(LOCK_MAX);
  // Return pipeline: one 4-bit stage per cycle of read latency,
  // stage = {valid, master, is_read, out_of_range}.
  localparam int          PW         = RD_LAT * 4;

  logic [1:0]    state_q, state_d;
  logic          prio_q, prio_d;        // 0: m0 has priority, 1: m1
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]    no_relock_q, no_relock_d;
  logic [PW-1:0] pipe_q, pipe_d;

  logic          win_v;
  logic          win_m;
  logic          own_active;
  logic          sel_we;
  logic          sel_lock;
  logic [15:0]   sel_addr;
  logic [63:0]   sel_wdata;
  logic          sel_in_range;
  logic [7:0]    cnt_inc;
  logic [3:0]    stage_in;
  logic [3:0]    stage_out;

  // Winner selection. An owner that keeps requesting beats everything;
  // otherwise plain round-robin between the requesters.
  always_comb begin
    own_active = 1'b0;
    win_m      = 1'b0;
    if ((state_q == ST_OWN0) && m0_req) begin
      own_active = 1'b1;
      win_m      = 1'b0;
    end else if ((state_q == ST_OWN1) && m1_req) begin
      own_active = 1'b1;
      win_m      = 1'b1;
    end else if (m0_req && m1_req) begin
      win_m      = prio_q;
    end else begin
      win_m      = m1_req;
    end
    // Nothing is granted while reset is asserted.
    win_v = reset_n & (m0_req | m1_req);
  end

  assign sel_we       = win_m ? m1_we    : m0_we;
  assign sel_lock     = win_m ? m1_lock  : m0_lock;
  assign sel_addr     = win_m ? m1_addr  : m0_addr;
  assign sel_wdata    = win_m ? m1_wdata : m0_wdata;
  assign sel_in_range = (sel_addr < ADDR_LIMIT);

  assign m0_gnt   = win_v & ~win_m;
  assign m1_gnt   = win_v &  win_m;
  assign rf_addr  = win_v ? sel_addr  : 16'd0;
  assign rf_wdata = win_v ? sel_wdata : 64'd0;
  assign rf_we    = win_v & sel_we & sel_in_range;

  assign cnt_inc  = lock_cnt_q + 8'd1;

  // Lock FSM and priority pointer.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    lock_cnt_d  = lock_cnt_q;
    no_relock_d = 2'b00;
    if (win_v) begin
      prio_d = ~win_m;
      if (own_active) begin
        // lock_cnt counts grants in the current locked run; the grant that
        // brings it to LOCK_MAX is the last one and forces a release.
        if (sel_lock && (cnt_inc < LOCK_LIMIT)) begin
          lock_cnt_d = cnt_inc;
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = 8'd0;
          if (sel_lock) begin
            no_relock_d[win_m] = 1'b1;
          end
        end
      end else if (sel_lock && !no_relock_q[win_m]) begin
        state_d    = win_m ? ST_OWN1 : ST_OWN0;
        lock_cnt_d = 8'd1;
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = 8'd0;
      end
    end else begin
      // No grant at all: an owner without a request gives up ownership.
      state_d    = ST_IDLE;
      lock_cnt_d = 8'd0;
    end
  end

  // Writes in range need no return; everything else comes back RD_LAT
  // cycles later as a read return and/or an error flag.
  assign stage_in = {win_v & (~sel_we | ~sel_in_range), win_m, ~sel_we, ~sel_in_range};

  always_comb begin
    pipe_d = PW'({pipe_q, stage_in});
  end

  assign stage_out = pipe_q[PW-1 -: 4];

  assign m0_rvalid = stage_out[3] & ~stage_out[2] & stage_out[1];
  assign m1_rvalid = stage_out[3] &  stage_out[2] & stage_out[1];
  assign m0_err    = stage_out[3] & ~stage_out[2] & stage_out[0];
  assign m1_err    = stage_out[3] &  stage_out[2] & stage_out[0];
  assign rdata     = (stage_out[3] & stage_out[1] & ~stage_out[0]) ? rf_rdata : 64'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      lock_cnt_q  <= 8'd0;
      no_relock_q <= 2'b00;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      lock_cnt_q  <= lock_cnt_d;
      no_relock_q <= no_relock_d;
      pipe_q      <= pipe_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_arbiter                                              |
// | Description : Self-checking bench for rf_arbiter. Hosts a register-file  |
// |               model, a transaction-level reference of the arbiter and a  |
// |               per-cycle compare, plus directed scenarios with literal    |
// |               expectations.                                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rf_arbiter;
  localparam int NUM_REGS = 23;
  localparam int RD_LAT   = 1;
  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [63:0] rdata, rf_wdata, rf_rdata;
  logic [15:0] rf_addr;
  logic        rf_we;

  always #5 clk = ~clk;

  rf_arbiter #(.NUM_REGS(NUM_REGS), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .rdata(rdata), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
  );

  // Register file environment: registered read, RD_LAT cycles.
  // Out-of-range reads return a junk pattern the arbiter must suppress.
  logic [63:0] rf_mem  [NUM_REGS];
  logic [63:0] rf_pipe [RD_LAT];
  always @(posedge clk) begin
    if (rf_we && rf_addr < NUM_REGS) rf_mem[int'(rf_addr)] <= rf_wdata;
    rf_pipe[0] <= (rf_addr < NUM_REGS) ? rf_mem[int'(rf_addr)] : 64'hA5A5_A5A5_A5A5_A5A5;
    for (int i = 1; i < RD_LAT; i++) rf_pipe[i] <= rf_pipe[i-1];
  end
  assign rf_rdata = rf_pipe[RD_LAT-1];

  // Reference model state.
  typedef struct {
    int          due;
    int          m;
    bit          rd;
    bit          oor;
    logic [63:0] data;
  } ret_t;
  ret_t        retq[$];
  logic [63:0] shadow [NUM_REGS];
  int          m_prio, m_owner, m_run, m_norelock, cyc;
  int          errors = 0;
  int          checks = 0;

  logic        s_gnt0, s_gnt1, s_rv0, s_rv1, s_err0, s_err1, s_rf_we;
  logic [15:0] s_rf_addr;
  logic [63:0] s_rf_wdata, s_rdata;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_owner = -1; m_run = 0; m_norelock = -1;
    retq.delete();
  endtask

  // One clock cycle: inputs are already applied; sample at the falling edge,
  // compare against the model, then advance the model over the rising edge.
  task automatic step();
    bit [1:0]    rq;
    int          w, nr;
    bit          oor, we, lk;
    logic [15:0] a;
    logic [63:0] wd;
    ret_t        r;
    logic        e_g0, e_g1, e_rv0, e_rv1, e_er0, e_er1, e_we;
    logic [15:0] e_addr;
    logic [63:0] e_wdata, e_rdata;
    @(negedge clk);
    s_gnt0 = m0_gnt; s_gnt1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
    s_err0 = m0_err; s_err1 = m1_err; s_rf_we = rf_we; s_rf_addr = rf_addr;
    s_rf_wdata = rf_wdata; s_rdata = rdata;
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0; e_we = 0;
    e_addr = 0; e_wdata = 0; e_rdata = 0;
    w = -1; oor = 0; we = 0; lk = 0; a = 0; wd = 0;
    if (reset_n) begin
      rq = {m1_req, m0_req};
      if (m_owner >= 0 && rq[m_owner]) w = m_owner;
      else if (rq == 2'b11) w = m_prio;
      else if (rq == 2'b01) w = 0;
      else if (rq == 2'b10) w = 1;
      if (retq.size() > 0 && retq[0].due == cyc) begin
        r = retq.pop_front();
        if (r.m == 0) begin e_rv0 = r.rd; e_er0 = r.oor; end
        else          begin e_rv1 = r.rd; e_er1 = r.oor; end
        e_rdata = r.rd ? r.data : 64'd0;
      end
      if (w >= 0) begin
        a  = (w == 1) ? m1_addr  : m0_addr;
        wd = (w == 1) ? m1_wdata : m0_wdata;
        we = (w == 1) ? m1_we    : m0_we;
        lk = (w == 1) ? m1_lock  : m0_lock;
        oor = (a >= NUM_REGS);
        e_g0 = (w == 0); e_g1 = (w == 1);
        e_addr = a; e_wdata = wd; e_we = we && !oor;
      end
    end
    chk("m0_gnt", s_gnt0, e_g0);       chk("m1_gnt", s_gnt1, e_g1);
    chk("rf_we", s_rf_we, e_we);       chk("rf_addr", s_rf_addr, e_addr);
    chk("rf_wdata", s_rf_wdata, e_wdata);
    chk("m0_rvalid", s_rv0, e_rv0);    chk("m1_rvalid", s_rv1, e_rv1);
    chk("m0_err", s_err0, e_er0);      chk("m1_err", s_err1, e_er1);
    chk("rdata", s_rdata, e_rdata);
    if (!reset_n) begin
      model_reset();
    end else if (w >= 0) begin
      if (!we || oor) begin
        r.due = cyc + RD_LAT; r.m = w; r.rd = !we; r.oor = oor;
        r.data = (!we && !oor) ? shadow[int'(a)] : 64'd0;
        retq.push_back(r);
      end
      if (we && !oor) shadow[int'(a)] = wd;
      nr = -1;
      if (m_owner == w) begin
        if (lk) begin
          m_run++;
          if (m_run == LOCK_MAX) begin m_owner = -1; m_run = 0; nr = w; end
        end else begin
          m_owner = -1; m_run = 0;
        end
      end else if (lk && m_norelock != w) begin
        m_owner = w; m_run = 1;
      end else begin
        m_owner = -1; m_run = 0;
      end
      m_norelock = nr;
      m_prio = 1 - w;
    end else begin
      m_owner = -1; m_run = 0; m_norelock = -1;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic set_m(int m, bit req, bit we, bit lock, logic [15:0] addr, logic [63:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, 16'd0, 64'd0);
    set_m(1, 0, 0, 0, 16'd0, 64'd0);
  endtask

  task automatic rand_m(int m);
    bit          r  = ($urandom_range(0, 9) < 7);
    bit          we = 1'($urandom_range(0, 1));
    bit          lk = ($urandom_range(0, 9) < 6);
    logic [15:0] a;
    a = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, NUM_REGS + 2));
    set_m(m, r, we, lk, a, {$urandom, $urandom});
  endtask

  bit t3_exp [12];

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_mem[i] <= 64'd0;
      shadow[i] = 64'd0;
    end
    for (int i = 0; i < RD_LAT; i++) rf_pipe[i] <= 64'd0;
    cyc = 0;
    model_reset();
    idle_all();
    @(posedge clk); #1;

    // Reset: requests present but nothing may be granted or driven.
    set_m(0, 1, 1, 0, 16'd5, 64'h1111);
    set_m(1, 1, 0, 0, 16'd3, 64'h2222);
    step();
    chk("rst_m0_gnt", s_gnt0, 0);
    chk("rst_rf_we", s_rf_we, 0);
    step();
    reset_n = 1'b1;
    idle_all();

    // T6: idle, then simultaneous requests -> m0 wins.
    step();
    chk("t6_idle_rf_we", s_rf_we, 0);
    chk("t6_idle_rf_addr", s_rf_addr, 0);
    set_m(0, 1, 0, 0, 16'd1, 64'd0);
    set_m(1, 1, 0, 0, 16'd2, 64'd0);
    step();
    chk("t6_m0_wins", s_gnt0, 1);
    chk("t6_m1_waits", s_gnt1, 0);
    set_m(0, 0, 0, 0, 16'd0, 64'd0);
    step();
    idle_all();
    step();

    // T1: write then read back addr 5.
    set_m(0, 1, 1, 0, 16'd5, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("t1_wr_gnt", s_gnt0, 1);
    chk("t1_rf_we", s_rf_we, 1);
    set_m(0, 1, 0, 0, 16'd5, 64'd0);
    step();
    chk("t1_rd_gnt", s_gnt0, 1);
    idle_all();
    repeat (RD_LAT) step();
    chk("t1_rvalid", s_rv0, 1);
    chk("t1_rdata", s_rdata, 64'hDEAD_BEEF_0123_4567);

    // T2: distinct data, then both masters read every cycle.
    set_m(0, 1, 1, 0, 16'd7, 64'h0000_0000_0000_0777);
    step();
    idle_all();
    set_m(1, 1, 1, 0, 16'd8, 64'h0000_0000_0000_0888);
    step();
    for (int k = 0; k < 6; k++) begin
      set_m(0, 1, 0, 0, 16'd7, 64'd0);
      set_m(1, 1, 0, 0, 16'd8, 64'd0);
      step();
      chk("t2_alternate", s_gnt0, (k % 2 == 0));
    end
    idle_all();
    repeat (RD_LAT + 1) step();

    // T3: m0 locks with req held 12 cycles against a constant m1 request.
    for (int k = 0; k < 12; k++) t3_exp[k] = (k != 8);
    for (int k = 0; k < 12; k++) begin
      set_m(0, 1, 0, 1, 16'd3, 64'd0);
      set_m(1, 1, 0, 0, 16'd4, 64'd0);
      step();
      chk("t3_lock_seq", s_gnt0, t3_exp[k]);
    end
    idle_all();
    repeat (RD_LAT + 1) step();

    // T4: out-of-range write and read from m1.
    set_m(1, 1, 1, 0, 16'd23, 64'h1234_5678_9ABC_DEF0);
    step();
    chk("t4_wr_gnt", s_gnt1, 1);
    chk("t4_wr_rf_we", s_rf_we, 0);
    set_m(1, 1, 0, 0, 16'hFFFF, 64'd0);
    step();
    chk("t4_wr_err", s_err1, 1);
    chk("t4_wr_no_rvalid", s_rv1, 0);
    idle_all();
    repeat (RD_LAT) step();
    chk("t4_rd_rvalid", s_rv1, 1);
    chk("t4_rd_err", s_err1, 1);
    chk("t4_rd_rdata", s_rdata, 64'd0);

    // T5: reset mid-operation discards pending returns and restores prio.
    set_m(0, 1, 0, 0, 16'd5, 64'd0);
    step();
    chk("t5_gnt", s_gnt0, 1);
    #3 reset_n = 1'b0;
    step();
    chk("t5_rst_rvalid", s_rv0, 0);
    chk("t5_rst_rdata", s_rdata, 0);
    step();
    reset_n = 1'b1;
    idle_all();
    repeat (RD_LAT + 2) begin
      step();
      chk("t5_no_late_rvalid", s_rv0, 0);
    end
    set_m(0, 1, 0, 0, 16'd9, 64'd0);
    set_m(1, 1, 0, 0, 16'd10, 64'd0);
    step();
    chk("t5_prio_m0", s_gnt0, 1);

    // Random traffic; a request is held until granted.
    for (int k = 0; k < 3000; k++) begin
      if (!m0_req || s_gnt0) rand_m(0);
      if (!m1_req || s_gnt1) rand_m(1);
      step();
    end
    idle_all();
    repeat (RD_LAT + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
